// File: rtl/timer_sched_pkg.sv
// ============================================================================
// Module  : timer_sched_pkg
// Purpose : Shared types and defaults for the shared-interval timer scheduler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    localparam int DUR_W_DEF   = 5;
    localparam int NUM_REQ_MAX = 8;

endpackage

`default_nettype wire

// File: rtl/timer_scheduler_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin picker; first set request at or after rr_ptr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt_nxt,
    output logic [IDX_W-1:0]   idx_nxt,
    output logic               any_req
);

    always_comb begin
        logic [IDX_W:0] pos;
        gnt_nxt = '0;
        idx_nxt = '0;
        any_req = 1'b0;
        pos     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Wrap the search index without a modulo operator.
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_req && req[pos[IDX_W-1:0]]) begin
                any_req                  = 1'b1;
                idx_nxt                  = pos[IDX_W-1:0];
                gnt_nxt[pos[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_scheduler.sv
// ============================================================================
// Module  : timer_scheduler
// Purpose : Shares one interval timer among NUM_REQ requesters with round-robin
//           grants. Optional cancel/abort support under TIMER_SCHED_CANCEL_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = DUR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DUR_W-1:0]    req_dur,
`ifdef TIMER_SCHED_CANCEL_EN
    input  logic [NUM_REQ-1:0]          cancel,
    output logic                        aborted,
`endif
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  cur_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
            $error("timer_scheduler: NUM_REQ out of range");
        end
    endgenerate

    sched_state_e        state_q, state_d;
    logic [DUR_W-1:0]    cnt_q;
    logic [DUR_W-1:0]    dur_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    cur_id_q;
    logic [NUM_REQ-1:0]  grant_q;

    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic                any_req;
    logic [DUR_W-1:0]    dur_sel;
    logic [DUR_W-1:0]    dur_eff;
    logic [IDX_W-1:0]    ptr_inc;
    logic                term;
    logic                cancel_hit;
    logic                stop;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_nxt (gnt_nxt),
        .idx_nxt (idx_nxt),
        .any_req (any_req)
    );

    always_comb begin
        dur_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                dur_sel = req_dur[i*DUR_W +: DUR_W];
            end
        end
    end

    // A zero duration is serviced as a single-cycle interval.
    assign dur_eff = (dur_q == '0) ? DUR_W'(1) : dur_q;
    assign term    = (state_q == RUN) && (cnt_q == dur_eff);
    assign ptr_inc = (cur_id_q == IDX_W'(NUM_REQ-1)) ? '0 : cur_id_q + IDX_W'(1);

`ifdef TIMER_SCHED_CANCEL_EN
    // Completion takes priority over a coincident cancel.
    assign cancel_hit = (state_q == RUN) && cancel[cur_id_q] && !term;
`else
    assign cancel_hit = 1'b0;
`endif

    assign stop = term || cancel_hit;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = RUN;
            RUN:     if (stop)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            done[i] = term && (cur_id_q == IDX_W'(i));
        end
        busy = (state_q == RUN);
`ifdef TIMER_SCHED_CANCEL_EN
        aborted = cancel_hit;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dur_q    <= '0;
            rr_ptr_q <= '0;
            cur_id_q <= '0;
            grant_q  <= '0;
        end else if (state_q == IDLE) begin
            if (any_req) begin
                grant_q  <= gnt_nxt;
                cur_id_q <= idx_nxt;
                dur_q    <= dur_sel;
                cnt_q    <= DUR_W'(1);
            end
        end else if (stop) begin
            grant_q  <= '0;
            cur_id_q <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= ptr_inc;
        end else begin
            cnt_q <= cnt_q + DUR_W'(1);
        end
    end

    assign grant  = grant_q;
    assign cur_id = cur_id_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_scheduler.sv
// ============================================================================
// Module  : tb_timer_scheduler
// Purpose : Directed bench for timer_scheduler with an interval-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_timer_scheduler;

    localparam int N  = 4;
    localparam int DW = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*DW-1:0] req_dur = '0;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
    logic [1:0]   cur_id;
`ifdef TIMER_SCHED_CANCEL_EN
    logic [N-1:0] cancel = '0;
    logic         aborted;
`endif

    timer_scheduler #(.NUM_REQ(N), .DUR_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_dur (req_dur),
`ifdef TIMER_SCHED_CANCEL_EN
        .cancel  (cancel),
        .aborted (aborted),
`endif
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .cur_id  (cur_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks whole intervals (owner, completion cycle)
    // ------------------------------------------------------------------
    bit m_job = 1'b0;
    int m_owner = 0;
    int m_end = 0;
    int m_ptr = 0;
    int cyc = 0;

    function automatic int dur_eff_of(input int i);
        int d;
        d = int'(req_dur[i*DW +: DW]);
        return (d == 0) ? 1 : d;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        logic         ea;
        cyc++;
        if (!rst_n) begin
            m_job = 1'b0;
            m_ptr = 0;
            chk("rst_grant", grant, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cur_id", cur_id, 0);
        end else begin
            eg = m_job ? N'(1 << m_owner) : '0;
            ed = (m_job && cyc == m_end) ? eg : '0;
            ea = 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
            ea = m_job && cancel[m_owner] && (cyc != m_end);
            chk("mdl_aborted", aborted, ea);
`endif
            chk("mdl_grant", grant, eg);
            chk("mdl_done", done, ed);
            chk("mdl_busy", busy, m_job);
            chk("mdl_cur_id", cur_id, m_job ? m_owner : 0);
            if (m_job && (cyc == m_end || ea)) begin
                m_job = 1'b0;
                m_ptr = (m_owner + 1) % N;
            end else if (!m_job && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_job && req[(m_ptr + k) % N]) begin
                        m_job   = 1'b1;
                        m_owner = (m_ptr + k) % N;
                    end
                end
                m_end = cyc + dur_eff_of(m_owner);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change at posedge+1, logs sample at posedge+3
    // ------------------------------------------------------------------
    logic [N-1:0] gl[$];
    logic [N-1:0] dl[$];
    logic         bl[$];
    logic [1:0]   il[$];

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #2;
        gl.push_back(grant);
        dl.push_back(done);
        bl.push_back(busy);
        il.push_back(cur_id);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cyc_start();
            sample();
        end
    endtask

    task automatic clear_log();
        gl.delete();
        dl.delete();
        bl.delete();
        il.delete();
    endtask

    task automatic set_dur(input int i, input int d);
        req_dur[i*DW +: DW] = DW'(d);
    endtask

    task automatic do_reset();
        req = '0;
        cyc_start();
        rst_n = 1'b0;
        cyc_start();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        req = '0;
        cyc_start();
        #2;
        while (busy && n < 64) begin
            cyc_start();
            #2;
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int order[5];
        int dcyc[5];
        int found;
        int gcount;

        // Reset values
        repeat (3) @(posedge clk);
        #3;
        chk("t0_grant", grant, 0);
        chk("t0_busy", busy, 0);
        chk("t0_cur_id", cur_id, 0);
        rst_n = 1'b1;

        // 1: single request, dur 5
        clear_log();
        cyc_start(); req = 4'b0001; set_dur(0, 5); sample();
        cyc_start(); req = 4'b0000; sample();
        run(6);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("t1_grant_%0d", k), gl[k], (k <= 5) ? 4'b0001 : 4'b0000);
            chk($sformatf("t1_done_%0d", k), dl[k], (k == 5) ? 4'b0001 : 4'b0000);
        end
        chk("t1_busy_after", bl[6], 0);

        // 2: all four requesting, dur 2 each
        do_reset();
        clear_log();
        cyc_start(); req = 4'b1111; for (int i = 0; i < N; i++) set_dur(i, 2); sample();
        run(20);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            if (found < 5 && dl[k] != '0) begin
                order[found] = int'(il[k]);
                dcyc[found]  = k;
                found++;
            end
        end
        chk("t2_found", found, 5);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("t2_order_%0d", j), order[j], j % N);
            chk($sformatf("t2_done_cyc_%0d", j), dcyc[j], 2 + 3 * j);
        end
        chk("t2_gap", gl[3], 0);
        wait_idle();

        // 3: zero duration and maximum duration
        do_reset();
        clear_log();
        cyc_start(); req = 4'b0110; set_dur(1, 0); set_dur(2, 31); sample();
        run(40);
        chk("t3_g1", gl[1], 4'b0010);
        chk("t3_d1", dl[1], 4'b0010);
        chk("t3_gap", gl[2], 0);
        gcount = 0;
        for (int k = 3; k <= 33; k++) if (gl[k] == 4'b0100) gcount++;
        chk("t3_g2_len", gcount, 31);
        chk("t3_d2_early", dl[32], 0);
        chk("t3_d2", dl[33], 4'b0100);
        wait_idle();

        // 4: asynchronous reset mid-interval, pointer must return to 0
        do_reset();
        cyc_start(); req = 4'b0010; set_dur(1, 1);
        cyc_start(); req = 4'b0000;
        cyc_start();
        cyc_start(); req = 4'b0100; set_dur(2, 20);
        cyc_start(); req = 4'b0000;
        repeat (9) cyc_start();
        #2;
        chk("t4_running", grant, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("t4_async_grant", grant, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_done", done, 0);
        cyc_start();
        cyc_start();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_dur(i, 3);
        cyc_start();
        req = 4'b0000;
        #2;
        chk("t4_ptr_reset_id", cur_id, 0);
        chk("t4_ptr_reset_grant", grant, 4'b0001);
        wait_idle();

        // 5: request dropped and duration changed mid-interval
        clear_log();
        cyc_start(); req = 4'b0001; set_dur(0, 8); sample();
        run(2);
        cyc_start(); req = 4'b0000; set_dur(0, 1); sample();
        run(7);
        for (int k = 1; k <= 7; k++) chk($sformatf("t5_nodone_%0d", k), dl[k], 0);
        chk("t5_done", dl[8], 4'b0001);
        chk("t5_grant_last", gl[8], 4'b0001);
        chk("t5_grant_off", gl[9], 0);
        wait_idle();

`ifdef TIMER_SCHED_CANCEL_EN
        // 6: cancel mid-interval, then cancel coinciding with completion
        do_reset();
        cyc_start(); req = 4'b0100; set_dur(2, 9);
        cyc_start(); req = 4'b0000;
        cyc_start(); cancel = 4'b0001;
        cyc_start(); cancel = 4'b0000;
        cyc_start(); cancel = 4'b0100;
        #2;
        chk("t6_aborted", aborted, 1);
        chk("t6_no_done", done, 0);
        cyc_start(); cancel = 4'b0000;
        #2;
        chk("t6_grant_off", grant, 0);
        chk("t6_abort_pulse", aborted, 0);
        cyc_start(); req = 4'b0100; set_dur(2, 3);
        cyc_start(); req = 4'b0000;
        cyc_start();
        cyc_start(); cancel = 4'b0100;
        #2;
        chk("t6_done_wins", done, 4'b0100);
        chk("t6_no_abort", aborted, 0);
        cyc_start(); cancel = 4'b0000;
        #2;
        chk("t6_idle", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
